// File: rtl/full_adder_18bit_dff_sync.sv
// Registered ripple-carry adder: 18-bit operands plus carry-in, 19-bit result
// appearing one clock after the operands are sampled.

`timescale 1ns/1ps

// One-bit full-adder cell used as a link in the ripple-carry chain.
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic w_p;

    // Propagate term, shared by the sum and the carry-out.
    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);

endmodule

module full_adder_18bit_dff_sync #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             rstn,   // active-high synchronous reset despite the name
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum_bits;
    logic [WIDTH:0]   w_result;
    logic [WIDTH:0]   r_sum;

    assign w_carry[0] = c_in;

    // Ripple chain: each cell's carry-out feeds the next cell's carry-in.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        full_adder_cell u_cell (
            .i_a (a[i]),
            .i_b (b[i]),
            .i_c (w_carry[i]),
            .o_s (w_sum_bits[i]),
            .o_c (w_carry[i+1])
        );
    end

    // Final carry becomes the top result bit, so nothing is truncated.
    assign w_result = {w_carry[WIDTH], w_sum_bits};

    // Result register loads every edge; reset takes priority and clears it.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_result;
        end
    end

    assign sum = r_sum;

endmodule

// File: tb/tb_full_adder_18bit_dff_sync.sv
// Directed bench for the registered 18-bit adder: vector table, streaming,
// mid-stream reset and hold/stability sequences.

`timescale 1ns/1ps

module tb_full_adder_18bit_dff_sync;

    logic        clk;
    logic        rstn;
    logic [17:0] a;
    logic [17:0] b;
    logic        c_in;
    logic [18:0] sum;

    int n_cmp;
    int n_fail;

    typedef struct {
        string       name;
        logic        rst;
        logic [17:0] a;
        logic [17:0] b;
        logic        c;
        logic [18:0] exp;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    full_adder_18bit_dff_sync #(.WIDTH(18)) dut (
        .clk  (clk),
        .rstn (rstn),
        .a    (a),
        .b    (b),
        .c_in (c_in),
        .sum  (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: sum=%05h expected=%05h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next rising edge and settle 2 ns past it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [18:0] exp_prev;
        logic [17:0] sa;
        logic [17:0] sb;

        n_cmp  = 0;
        n_fail = 0;

        vecs[0]  = '{"reset",        1'b1, 18'h12345, 18'h00ABC, 1'b0, 19'h00000};
        vecs[1]  = '{"max_c0",       1'b0, 18'h3FFFF, 18'h3FFFF, 1'b0, 19'h7FFFE};
        vecs[2]  = '{"max_c1",       1'b0, 18'h3FFFF, 18'h3FFFF, 1'b1, 19'h7FFFF};
        vecs[3]  = '{"ripple_full",  1'b0, 18'h3FFFF, 18'h00000, 1'b1, 19'h40000};
        vecs[4]  = '{"zero",         1'b0, 18'h00000, 18'h00000, 1'b0, 19'h00000};
        vecs[5]  = '{"cin_only",     1'b0, 18'h00000, 18'h00000, 1'b1, 19'h00001};
        vecs[6]  = '{"mixed",        1'b0, 18'h12345, 18'h00ABC, 1'b0, 19'h12E01};
        vecs[7]  = '{"alt_bits",     1'b0, 18'h15555, 18'h2AAAA, 1'b0, 19'h3FFFF};
        vecs[8]  = '{"alt_bits_c1",  1'b0, 18'h15555, 18'h2AAAA, 1'b1, 19'h40000};
        vecs[9]  = '{"msb_carry",    1'b0, 18'h20000, 18'h20000, 1'b0, 19'h40000};
        vecs[10] = '{"mid_ripple",   1'b0, 18'h1FFFF, 18'h00001, 1'b0, 19'h20000};
        vecs[11] = '{"same_alt",     1'b0, 18'h2AAAA, 18'h2AAAA, 1'b0, 19'h55554};
        vecs[12] = '{"same_alt_c1",  1'b0, 18'h2AAAA, 18'h2AAAA, 1'b1, 19'h55555};
        vecs[13] = '{"half_c1",      1'b0, 18'h0FFFF, 18'h0FFFF, 1'b1, 19'h1FFFF};

        // Table: drive, take one edge, compare result registered on that edge.
        for (int i = 0; i < NVEC; i++) begin
            rstn = vecs[i].rst;
            a    = vecs[i].a;
            b    = vecs[i].b;
            c_in = vecs[i].c;
            step();
            check(vecs[i].name, sum, vecs[i].exp);
        end

        // Stream: new operands every edge; result must hold until the next edge.
        rstn = 1'b0;
        c_in = 1'b0;
        for (int i = 0; i < 100; i++) begin
            sa = 18'((i * 32'h1357 + 32'h0F0F) & 32'h3FFFF);
            sb = 18'((i * 32'h2468 ^ 32'h3C3C3) & 32'h3FFFF);
            a  = sa;
            b  = sb;
            step();
            exp_prev = 19'(sa) + 19'(sb);
            check("stream", sum, exp_prev);
            a = ~sa;
            b = ~sb;
            #6;
            check("stream_hold", sum, exp_prev);
        end

        // Mid-stream reset discards the in-flight result.
        a    = 18'h3FFFF;
        b    = 18'h3FFFF;
        c_in = 1'b1;
        rstn = 1'b1;
        step();
        check("midreset", sum, 19'h00000);
        rstn = 1'b0;
        a    = 18'h00001;
        b    = 18'h00002;
        c_in = 1'b0;
        step();
        check("post_reset", sum, 19'h00003);

        // Hold operands for three edges; result stays steady across each cycle.
        a    = 18'h15555;
        b    = 18'h2AAAA;
        c_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_edge", sum, 19'h3FFFF);
            #6;
            check("hold_mid", sum, 19'h3FFFF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
